// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, bus types and constants for the register file
package regfile_wb_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int PW   = 2;

    typedef logic [XLEN-1:0] reg_bus_t;
    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [PW-1:0]   pend_cnt_t;

    localparam reg_bus_t  ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam pend_cnt_t PEND_MAX     = '1;

endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - writeback, read-port and issue signals of the register file
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic      wb_wreg;
    reg_addr_t wb_rd;
    reg_bus_t  wb_wdata;
    logic      re1;
    logic      re2;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    reg_bus_t  rdata1;
    reg_bus_t  rdata2;
    logic      busy1;
    logic      busy2;
    logic      issue_valid;
    reg_addr_t issue_rd;
    logic      issue_ready;
    logic      flush;

    modport master (
        output wb_wreg, wb_rd, wb_wdata, re1, re2, raddr1, raddr2,
               issue_valid, issue_rd, flush,
        input  rdata1, rdata2, busy1, busy2, issue_ready
    );

    modport slave (
        input  wb_wreg, wb_rd, wb_wdata, re1, re2, raddr1, raddr2,
               issue_valid, issue_rd, flush,
        output rdata1, rdata2, busy1, busy2, issue_ready
    );

endinterface

// File: rtl/pend_ctr.sv
// rtl/pend_ctr.sv - saturating up/down count of writes in flight to one register
module pend_ctr
    import regfile_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      inc,
    input  logic      dec,
    output pend_cnt_t cnt
);

    logic inc_ok;
    logic dec_ok;

    // A writeback with nothing pending is not a decrement, so it cannot cancel an issue.
    assign inc_ok = inc && (cnt != PEND_MAX);
    assign dec_ok = dec && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - integer register file with writeback bypass and pending-write scoreboard
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);

    reg_bus_t  mem [NREG];
    pend_cnt_t cnt [NREG];
    logic [NREG-1:1] inc;
    logic [NREG-1:1] dec;
    logic      wb_commit;
    logic      issue_go;
    logic      issue_ready;
    logic      hit1;
    logic      hit2;

    assign wb_commit = bus.wb_wreg && (bus.wb_rd != NOP_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= ZERO_WORD;
            end
        end else if (wb_commit) begin
            mem[bus.wb_rd] <= bus.wb_wdata;
        end
    end

    assign issue_ready = !((bus.issue_rd != NOP_REG_ADDR) && (cnt[bus.issue_rd] == PEND_MAX));
    assign issue_go    = bus.issue_valid && (bus.issue_rd != NOP_REG_ADDR) && issue_ready && !bus.flush;
    assign bus.issue_ready = issue_ready;

    // x0 never has a counter; its slot is held at zero so lookups need no special case.
    assign cnt[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_pend
        assign inc[g] = issue_go && (bus.issue_rd == AW'(g));
        assign dec[g] = bus.wb_wreg && (bus.wb_rd == AW'(g));

        pend_ctr u_pend_ctr (
            .clk (clk),
            .rst (rst),
            .clr (bus.flush),
            .inc (inc[g]),
            .dec (dec[g]),
            .cnt (cnt[g])
        );
    end

    assign hit1 = bus.re1 && bus.wb_wreg && (bus.raddr1 != NOP_REG_ADDR) && (bus.wb_rd == bus.raddr1);
    assign hit2 = bus.re2 && bus.wb_wreg && (bus.raddr2 != NOP_REG_ADDR) && (bus.wb_rd == bus.raddr2);

    assign bus.rdata1 = (!bus.re1 || bus.raddr1 == NOP_REG_ADDR) ? ZERO_WORD :
                        hit1 ? bus.wb_wdata : mem[bus.raddr1];
    assign bus.rdata2 = (!bus.re2 || bus.raddr2 == NOP_REG_ADDR) ? ZERO_WORD :
                        hit2 ? bus.wb_wdata : mem[bus.raddr2];

    // The write being bypassed right now no longer counts as outstanding.
    assign bus.busy1 = bus.re1 && (bus.raddr1 != NOP_REG_ADDR) &&
                       (hit1 ? (cnt[bus.raddr1] > PW'(1)) : (cnt[bus.raddr1] != '0));
    assign bus.busy2 = bus.re2 && (bus.raddr2 != NOP_REG_ADDR) &&
                       (hit2 ? (cnt[bus.raddr2] > PW'(1)) : (cnt[bus.raddr2] != '0));

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed and randomized self-checking bench for regfile_wb
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic clk;
    logic rst;
    regfile_wb_if bus ();

    regfile_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [31:0] mem_m [32];
    int          cnt_m [32];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic re, input logic [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (bus.wb_wreg && bus.wb_rd == a) return bus.wb_wdata;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic re, input logic [4:0] a);
        int pending;
        if (!re || a == 0) return 1'b0;
        pending = cnt_m[a];
        if (bus.wb_wreg && bus.wb_rd == a) pending = pending - 1;
        return pending > 0;
    endfunction

    function automatic logic exp_ready();
        return !(bus.issue_rd != 0 && cnt_m[bus.issue_rd] == 3);
    endfunction

    always @(posedge clk) begin
        logic inc_m;
        logic dec_m;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_m[i] = 32'h0;
                cnt_m[i] = 0;
            end
        end else begin
            inc_m = bus.issue_valid && bus.issue_rd != 0 && exp_ready() && !bus.flush;
            dec_m = bus.wb_wreg && bus.wb_rd != 0 && cnt_m[bus.wb_rd] != 0;
            if (bus.wb_wreg && bus.wb_rd != 0) mem_m[bus.wb_rd] = bus.wb_wdata;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) cnt_m[i] = 0;
            end else begin
                if (inc_m) cnt_m[bus.issue_rd] = cnt_m[bus.issue_rd] + 1;
                if (dec_m) cnt_m[bus.wb_rd] = cnt_m[bus.wb_rd] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_rdata1", bus.rdata1, exp_rdata(bus.re1, bus.raddr1));
            chk("model_rdata2", bus.rdata2, exp_rdata(bus.re2, bus.raddr2));
            chk("model_busy1", 32'(bus.busy1), 32'(exp_busy(bus.re1, bus.raddr1)));
            chk("model_busy2", 32'(bus.busy2), 32'(exp_busy(bus.re2, bus.raddr2)));
            chk("model_issue_ready", 32'(bus.issue_ready), 32'(exp_ready()));
        end
    end

    task automatic idle();
        bus.wb_wreg     = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_wdata    = '0;
        bus.re1         = 1'b0;
        bus.re2         = 1'b0;
        bus.raddr1      = '0;
        bus.raddr2      = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        bus.wb_wreg  = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_wdata = d;
    endtask

    task automatic rd1(input logic [4:0] a);
        bus.re1    = 1'b1;
        bus.raddr1 = a;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        checking = 1'b1;
        cyc();
        rst = 1'b0;

        // reset state
        rd1(5); bus.re2 = 1'b1; bus.raddr2 = 0; bus.issue_rd = 5; #2;
        chk("reset_rdata1", bus.rdata1, 32'h0);
        chk("reset_rdata2", bus.rdata2, 32'h0);
        chk("reset_busy1", 32'(bus.busy1), 32'h0);
        chk("reset_ready", 32'(bus.issue_ready), 32'h1);

        // bypass then array
        cyc(); idle(); wb(7, 32'hDEADBEEF); rd1(7); #2;
        chk("bypass_x7", bus.rdata1, 32'hDEADBEEF);
        cyc(); idle(); rd1(7); #2;
        chk("array_x7", bus.rdata1, 32'hDEADBEEF);

        // x0 protection
        cyc(); idle(); wb(0, 32'h12345678); rd1(0); bus.re2 = 1'b1; bus.raddr2 = 0; #2;
        chk("x0_bypass_p1", bus.rdata1, 32'h0);
        chk("x0_bypass_p2", bus.rdata2, 32'h0);
        cyc(); idle(); rd1(0); issue(0); #2;
        chk("x0_array_p1", bus.rdata1, 32'h0);
        chk("x0_issue_ready", 32'(bus.issue_ready), 32'h1);

        // saturate x3 then drain
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); issue(3);
        end
        cyc(); idle(); rd1(3); bus.issue_rd = 3; #2;
        chk("x3_busy_full", 32'(bus.busy1), 32'h1);
        chk("x3_ready_full", 32'(bus.issue_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); wb(3, 32'h300 + 32'(i)); rd1(3); #2;
            chk("x3_busy_drain", 32'(bus.busy1), (i == 2) ? 32'h0 : 32'h1);
            chk("x3_bypass_data", bus.rdata1, 32'h300 + 32'(i));
        end
        cyc(); idle(); rd1(3); bus.issue_rd = 3; #2;
        chk("x3_busy_after", 32'(bus.busy1), 32'h0);
        chk("x3_ready_after", 32'(bus.issue_ready), 32'h1);

        // simultaneous inc/dec on x9, spurious writeback to x10
        cyc(); idle(); issue(9);
        cyc(); idle(); issue(9); wb(9, 32'h99);
        cyc(); idle(); rd1(9); #2;
        chk("x9_busy_kept", 32'(bus.busy1), 32'h1);
        chk("x9_data", bus.rdata1, 32'h99);
        cyc(); idle(); wb(10, 32'h55);
        cyc(); idle(); rd1(10); bus.issue_rd = 10; #2;
        chk("x10_data", bus.rdata1, 32'h55);
        chk("x10_busy", 32'(bus.busy1), 32'h0);

        // flush with issue and writeback in the same cycle
        cyc(); idle(); issue(4);
        cyc(); idle(); issue(4);
        cyc(); idle(); rd1(4); #2;
        chk("x4_busy_pre", 32'(bus.busy1), 32'h1);
        cyc(); idle(); bus.flush = 1'b1; issue(4); wb(4, 32'hA5);
        cyc(); idle(); rd1(4); #2;
        chk("x4_flush_data", bus.rdata1, 32'hA5);
        chk("x4_flush_busy", 32'(bus.busy1), 32'h0);

        // randomized traffic on a narrow register range to force collisions
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst             = ($urandom_range(0, 399) == 0);
            bus.wb_wreg     = $urandom_range(0, 1) == 1;
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_wdata    = $urandom;
            bus.re1         = $urandom_range(0, 7) != 0;
            bus.re2         = $urandom_range(0, 7) != 0;
            bus.raddr1      = 5'($urandom_range(0, 7));
            bus.raddr2      = 5'($urandom_range(0, 7));
            bus.issue_valid = $urandom_range(0, 1) == 1;
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.flush       = ($urandom_range(0, 39) == 0);
        end
        cyc();
        rst = 1'b0;
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
